line_frame_counter: RTL and testbench

Parametrised line/frame timing counter for the Patterns video path. A horizontal counter tracks pixel position within a line, and a vertical counter tracks line position within a frame. Terminal counts come from a normal constant, a full-range test constant or run-time configuration. The block produces `end_line`/`end_frame` strobes and supports single-shot (one frame) operation. It replaces the fixed 12-bit line counter as the timing source for the pattern generators.

---
 rtl/patterns_pkg.sv | 16 +
 rtl/wrap_counter.sv | 31 +++
 rtl/line_frame_counter.sv | 113 +++++++++++
 tb/tb_line_frame_counter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/patterns_pkg.sv
// Shared encodings for the Patterns video path: mode select and timing FSM states.
package patterns_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_TEST   = 2'b01,
        MODE_PROG   = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/wrap_counter.sv
// Unsigned counter that returns to zero after reaching a supplied last value.
module wrap_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             at_last
);

    assign at_last = (count == last);

    // Wrap happens only through the compare, so an all-ones last never overflows early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            if (at_last) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/line_frame_counter.sv
// Line/frame timing source: horizontal and vertical wrap counters, limit latching
// at frame start, and an IDLE/ACTIVE/DONE run FSM with single-shot support.
module line_frame_counter
    import patterns_pkg::*;
#(
    parameter int H_WIDTH       = 12,
    parameter int V_WIDTH       = 11,
    parameter int H_NORMAL_LAST = 1289,
    parameter int V_NORMAL_LAST = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic [1:0]         mode,
    input  logic               single_shot,
    input  logic [H_WIDTH-1:0] cfg_h_last,
    input  logic [V_WIDTH-1:0] cfg_v_last,
    output logic [H_WIDTH-1:0] h_count,
    output logic [V_WIDTH-1:0] v_count,
    output logic               end_line,
    output logic               end_frame,
    output logic               active,
    output logic               frame_done
);

    state_e               state;
    logic [H_WIDTH-1:0]   h_last_q;
    logic [V_WIDTH-1:0]   v_last_q;
    logic [H_WIDTH-1:0]   h_last_sel;
    logic [V_WIDTH-1:0]   v_last_sel;
    logic                 h_at_last;
    logic                 v_at_last;
    logic                 run;
    logic                 cnt_clear;
    logic                 frame_wrap;

    always_comb begin
        h_last_sel = H_WIDTH'(H_NORMAL_LAST);
        v_last_sel = V_WIDTH'(V_NORMAL_LAST);
        case (mode)
            MODE_TEST: begin
                h_last_sel = '1;
                v_last_sel = '1;
            end
            MODE_PROG: begin
                h_last_sel = cfg_h_last;
                v_last_sel = cfg_v_last;
            end
            default: ;
        endcase
    end

    assign run        = (state == ST_ACTIVE);
    assign cnt_clear  = !enb || !run;
    assign frame_wrap = run && h_at_last && v_at_last;

    wrap_counter #(.WIDTH(H_WIDTH)) u_h_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .inc     (run),
        .last    (h_last_q),
        .count   (h_count),
        .at_last (h_at_last)
    );

    wrap_counter #(.WIDTH(V_WIDTH)) u_v_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .inc     (run && h_at_last),
        .last    (v_last_q),
        .count   (v_count),
        .at_last (v_at_last)
    );

    // Limits move only on frame start so mid-frame mode/cfg changes cannot tear a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            h_last_q <= H_WIDTH'(H_NORMAL_LAST);
            v_last_q <= V_WIDTH'(V_NORMAL_LAST);
        end else if (!enb) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_ACTIVE;
                    h_last_q <= h_last_sel;
                    v_last_q <= v_last_sel;
                end
                ST_ACTIVE: begin
                    if (frame_wrap) begin
                        if (single_shot) begin
                            state <= ST_DONE;
                        end else begin
                            h_last_q <= h_last_sel;
                            v_last_q <= v_last_sel;
                        end
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign end_line   = run && h_at_last;
    assign end_frame  = frame_wrap;
    assign active     = run;
    assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_line_frame_counter.sv
// Bench for line_frame_counter: frame-position model checked every cycle plus directed literal checks.
module tb_line_frame_counter;

    localparam int HW = 12;
    localparam int VW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enb = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          single_shot = 1'b0;
    logic [HW-1:0] cfg_h_last = '0;
    logic [VW-1:0] cfg_v_last = '0;
    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          end_line;
    logic          end_frame;
    logic          active;
    logic          frame_done;

    int total = 0;
    int bad   = 0;

    line_frame_counter #(
        .H_WIDTH(HW), .V_WIDTH(VW), .H_NORMAL_LAST(1289), .V_NORMAL_LAST(1023)
    ) dut (
        .clk(clk), .rst(rst), .enb(enb), .mode(mode), .single_shot(single_shot),
        .cfg_h_last(cfg_h_last), .cfg_v_last(cfg_v_last),
        .h_count(h_count), .v_count(v_count), .end_line(end_line),
        .end_frame(end_frame), .active(active), .frame_done(frame_done)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: run mode (0 idle, 1 running, 2 finished) and position within the frame.
    int m_run = 0;
    int m_pos = 0;
    int m_h   = 1289;
    int m_v   = 1023;

    function automatic int lim_h(input logic [1:0] md, input int cfg);
        if (md == 2'b01) return (1 << HW) - 1;
        if (md == 2'b10) return cfg;
        return 1289;
    endfunction

    function automatic int lim_v(input logic [1:0] md, input int cfg);
        if (md == 2'b01) return (1 << VW) - 1;
        if (md == 2'b10) return cfg;
        return 1023;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 0;
            m_pos <= 0;
            m_h   <= 1289;
            m_v   <= 1023;
        end else if (!enb) begin
            m_run <= 0;
            m_pos <= 0;
        end else if (m_run == 0) begin
            m_run <= 1;
            m_pos <= 0;
            m_h   <= lim_h(mode, int'(cfg_h_last));
            m_v   <= lim_v(mode, int'(cfg_v_last));
        end else if (m_run == 1) begin
            if (m_pos == (m_h + 1) * (m_v + 1) - 1) begin
                m_pos <= 0;
                if (single_shot) begin
                    m_run <= 2;
                end else begin
                    m_h <= lim_h(mode, int'(cfg_h_last));
                    m_v <= lim_v(mode, int'(cfg_v_last));
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    // scoreboard: every cycle the model's view of the outputs is compared
    always @(negedge clk) begin
        int eh, ev, el, ef;
        eh = (m_run == 1) ? m_pos % (m_h + 1) : 0;
        ev = (m_run == 1) ? m_pos / (m_h + 1) : 0;
        el = (m_run == 1 && eh == m_h) ? 1 : 0;
        ef = (el == 1 && ev == m_v) ? 1 : 0;
        chk("h_count", int'(h_count), eh);
        chk("v_count", int'(v_count), ev);
        chk("end_line", int'(end_line), el);
        chk("end_frame", int'(end_frame), ef);
        chk("active", int'(active), (m_run == 1) ? 1 : 0);
        chk("frame_done", int'(frame_done), (m_run == 2) ? 1 : 0);
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_idle();
        enb = 1'b0;
        step(1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst h_count", int'(h_count), 0);
        chk("rst active", int'(active), 0);
        chk("rst end_line", int'(end_line), 0);
        step(2);
        rst = 1'b0;
        step(1);

        // Normal mode: first end_line in ACTIVE cycle 1290
        mode = 2'b00;
        enb  = 1'b1;
        step(1);
        chk("nrm first active", int'(active), 1);
        chk("nrm first h", int'(h_count), 0);
        step(1288);
        chk("nrm cycle1289 end_line", int'(end_line), 0);
        step(1);
        chk("nrm cycle1290 h", int'(h_count), 1289);
        chk("nrm cycle1290 end_line", int'(end_line), 1);
        step(1);
        chk("nrm next v", int'(v_count), 1);
        chk("nrm next h", int'(h_count), 0);
        go_idle();

        // Mode 11 behaves as normal
        mode = 2'b11;
        enb  = 1'b1;
        step(1290);
        chk("m11 end_line", int'(end_line), 1);
        chk("m11 h", int'(h_count), 1289);
        go_idle();

        // Programmable 3/2, free running
        mode = 2'b10;
        cfg_h_last = 12'd3;
        cfg_v_last = 11'd2;
        enb = 1'b1;
        step(4);
        chk("prg cycle4 end_line", int'(end_line), 1);
        step(8);
        chk("prg cycle12 end_frame", int'(end_frame), 1);
        chk("prg cycle12 v", int'(v_count), 2);
        step(1);
        chk("prg restart h", int'(h_count), 0);
        chk("prg restart v", int'(v_count), 0);
        chk("prg restart active", int'(active), 1);
        go_idle();

        // Single shot
        single_shot = 1'b1;
        enb = 1'b1;
        step(12);
        chk("ss end_frame", int'(end_frame), 1);
        step(1);
        chk("ss frame_done", int'(frame_done), 1);
        chk("ss h held", int'(h_count), 0);
        step(3);
        chk("ss still done", int'(frame_done), 1);
        go_idle();
        chk("ss idle frame_done", int'(frame_done), 0);
        chk("ss idle active", int'(active), 0);
        enb = 1'b1;
        step(1);
        chk("ss restart active", int'(active), 1);
        go_idle();
        single_shot = 1'b0;

        // cfg_h_last changes mid-frame: effect only after the wrap
        cfg_h_last = 12'd3;
        enb = 1'b1;
        step(5);
        cfg_h_last = 12'd7;
        step(3);
        chk("chg cycle8 end_line", int'(end_line), 1);
        step(4);
        chk("chg cycle12 end_frame", int'(end_frame), 1);
        step(4);
        chk("chg cycle16 h", int'(h_count), 3);
        chk("chg cycle16 end_line", int'(end_line), 0);
        step(4);
        chk("chg cycle20 end_line", int'(end_line), 1);
        chk("chg cycle20 h", int'(h_count), 7);
        go_idle();

        // Test mode: full range wrap at all-ones
        mode = 2'b01;
        enb  = 1'b1;
        step(4095);
        chk("tst cycle4095 end_line", int'(end_line), 0);
        step(1);
        chk("tst cycle4096 h", int'(h_count), 4095);
        chk("tst cycle4096 end_line", int'(end_line), 1);
        step(1);
        chk("tst next v", int'(v_count), 1);
        go_idle();

        // Drop enb at h=2, v=1
        mode = 2'b10;
        cfg_h_last = 12'd3;
        cfg_v_last = 11'd2;
        enb = 1'b1;
        step(7);
        chk("drop pre h", int'(h_count), 2);
        chk("drop pre v", int'(v_count), 1);
        enb = 1'b0;
        step(1);
        chk("drop active", int'(active), 0);
        chk("drop h", int'(h_count), 0);
        chk("drop v", int'(v_count), 0);
        chk("drop end_line", int'(end_line), 0);

        // Asynchronous reset mid-frame
        enb = 1'b1;
        step(6);
        #2 rst = 1'b1;
        #1;
        chk("arst h", int'(h_count), 0);
        chk("arst v", int'(v_count), 0);
        chk("arst active", int'(active), 0);
        chk("arst end_line", int'(end_line), 0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("arst restart active", int'(active), 1);
        chk("arst restart h", int'(h_count), 0);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
